// File: rtl/rv_core_pkg.sv
// Shared RV32 core definitions: opcodes, the decoded control bundle and decode helpers.
package rv_core_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_R:             c.reg_write = 1'b1;
      OP_IMM:           begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      OP_LOAD:          begin
                          c.reg_write  = 1'b1;
                          c.mem_read   = 1'b1;
                          c.mem_to_reg = 1'b1;
                          c.alu_src    = 1'b1;
                        end
      OP_STORE:         begin c.mem_write = 1'b1; c.alu_src = 1'b1; end
      OP_BRANCH:        c.branch = 1'b1;
      OP_LUI, OP_AUIPC: begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
      OP_JAL:           begin c.reg_write = 1'b1; c.jump = 1'b1; end
      OP_JALR:          begin c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src = 1'b1; end
      default:          c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R || op == OP_STORE || op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate generator: sign-extended I/S/B/U/J immediate selected by opcode; zero otherwise.
module imm_gen
  import rv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm
);

  logic s;
  assign s = instr[31];

  always_comb begin
    imm = '0;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: imm = {{(XLEN-12){s}}, instr[31:20]};
      OP_STORE:                 imm = {{(XLEN-12){s}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm = {{(XLEN-12){s}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {{(XLEN-32){s}}, instr[31:12], 12'b0};
      OP_JAL:                   imm = {{(XLEN-20){s}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage + ID/EX pipeline register with load-use stall detection.
// Define ID_WB_BYPASS_EN to forward the writeback bus into the captured operands.
module id_ex_stage
  import rv_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Main_bus,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_valid,
  input  logic [XLEN-1:0] read_d1,
  input  logic [XLEN-1:0] read_d2,
  input  logic            flush,
  input  logic            wb_RegWrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [6:0]      ex_opcode,
  output logic            ex_RegWrite,
  output logic            ex_MemRead,
  output logic            ex_MemWrite,
  output logic            ex_MemToReg,
  output logic            ex_AluSrc,
  output logic            ex_Branch,
  output logic            ex_Jump,
  output logic            ex_illegal
);

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2, rd;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data, rs2_data;
  logic            bubble;

  assign opcode = Main_bus[6:0];
  assign rd     = Main_bus[11:7];
  assign rs1    = Main_bus[19:15];
  assign rs2    = Main_bus[24:20];
  assign ctrl   = decode_ctrl(opcode);

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (Main_bus),
    .imm   (imm)
  );

`ifdef ID_WB_BYPASS_EN
  // Register file writes at the same edge it is read; take the WB value directly.
  assign rs1_data = (wb_RegWrite && wb_rd != '0 && wb_rd == rs1) ? wb_data : read_d1;
  assign rs2_data = (wb_RegWrite && wb_rd != '0 && wb_rd == rs2) ? wb_data : read_d2;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_RegWrite, wb_rd, wb_data};
  assign rs1_data  = read_d1;
  assign rs2_data  = read_d2;
`endif

  assign stall = if_valid & ~flush & ex_valid & ex_MemRead & (ex_rd != '0) &
                 ((uses_rs1(opcode) & (ex_rd == rs1)) | (uses_rs2(opcode) & (ex_rd == rs2)));

  assign bubble = flush | stall | ~if_valid;

  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_opcode   <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemToReg <= 1'b0;
      ex_AluSrc   <= 1'b0;
      ex_Branch   <= 1'b0;
      ex_Jump     <= 1'b0;
      ex_illegal  <= 1'b0;
    end else begin
      ex_valid    <= 1'b1;
      ex_pc       <= if_pc;
      ex_rs1_data <= rs1_data;
      ex_rs2_data <= rs2_data;
      ex_imm      <= imm;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_rd       <= rd;
      ex_funct3   <= Main_bus[14:12];
      ex_funct7b5 <= Main_bus[30];
      ex_opcode   <= opcode;
      ex_RegWrite <= ctrl.reg_write & (rd != '0);
      ex_MemRead  <= ctrl.mem_read;
      ex_MemWrite <= ctrl.mem_write;
      ex_MemToReg <= ctrl.mem_to_reg;
      ex_AluSrc   <= ctrl.alu_src;
      ex_Branch   <= ctrl.branch;
      ex_Jump     <= ctrl.jump;
      ex_illegal  <= ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed test-plan cases followed by random traffic.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [6:0]  op;
    logic        rw, mr, mw, m2r, as, br, jp, ill;
  } ex_t;

  logic        clk, reset, if_valid, flush, wb_RegWrite;
  logic [31:0] Main_bus, if_pc, read_d1, read_d2, wb_data;
  logic [4:0]  wb_rd;
  logic        stall, ex_valid, ex_funct7b5;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_opcode;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemToReg, ex_AluSrc, ex_Branch, ex_Jump, ex_illegal;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .Main_bus(Main_bus), .if_pc(if_pc), .if_valid(if_valid),
    .read_d1(read_d1), .read_d2(read_d2), .flush(flush),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_opcode(ex_opcode),
    .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
    .ex_MemToReg(ex_MemToReg), .ex_AluSrc(ex_AluSrc), .ex_Branch(ex_Branch),
    .ex_Jump(ex_Jump), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  ex_t  ex_q[$];
  logic stall_q[$];
  ex_t  m;
  logic last_stall;

  // Reference: the instruction as EX should see it, straight from the opcode table and field layout.
  function automatic ex_t decode_model(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] d1, input logic [31:0] d2,
                                       input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
    ex_t r;
    logic [6:0] c;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    int v;
    r = '0;
    v = 0;
    r.ill = 1'b0;
    case (ins[6:0])
      7'b0110011: c = 7'b1000000;
      7'b0010011: c = 7'b1000100;
      7'b0000011: c = 7'b1101100;
      7'b0100011: c = 7'b0010100;
      7'b1100011: c = 7'b0000010;
      7'b0110111: c = 7'b1000100;
      7'b0010111: c = 7'b1000100;
      7'b1101111: c = 7'b1000001;
      7'b1100111: c = 7'b1000101;
      default:    begin c = 7'b0; r.ill = 1'b1; end
    endcase
    case (ins[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: begin i12 = ins[31:20]; v = i12; end
      7'b0100011: begin i12 = {ins[31:25], ins[11:7]}; v = i12; end
      7'b1100011: begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = b13; end
      7'b0110111, 7'b0010111: v = int'(ins[31:12]) * 4096;
      7'b1101111: begin j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = j21; end
      default: v = 0;
    endcase
`ifdef ID_WB_BYPASS_EN
    if (wbw && wbr != 0 && wbr == ins[19:15]) d1 = wbd;
    if (wbw && wbr != 0 && wbr == ins[24:20]) d2 = wbd;
`else
    if (wbw && wbr == 5'h1f && wbd == 32'h0) d1 = d1;
`endif
    r.valid = 1'b1;
    r.pc  = pc;
    r.d1  = d1;
    r.d2  = d2;
    r.imm = v;
    r.rs1 = ins[19:15];
    r.rs2 = ins[24:20];
    r.rd  = ins[11:7];
    r.f3  = ins[14:12];
    r.f7  = ins[30];
    r.op  = ins[6:0];
    r.rw  = c[6] && (ins[11:7] != 0);
    r.mr  = c[5];
    r.mw  = c[4];
    r.m2r = c[3];
    r.as  = c[2];
    r.br  = c[1];
    r.jp  = c[0];
    return r;
  endfunction

  task automatic step(input logic rst, input logic [31:0] ins, input logic [31:0] pc, input logic v,
                      input logic fl, input logic [31:0] d1, input logic [31:0] d2,
                      input logic wbw, input logic [4:0] wbr, input logic [31:0] wbd);
    logic u1, u2, es;
    @(posedge clk);
    #2;
    reset = rst; Main_bus = ins; if_pc = pc; if_valid = v; flush = fl;
    read_d1 = d1; read_d2 = d2; wb_RegWrite = wbw; wb_rd = wbr; wb_data = wbd;
    u1 = !(ins[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    u2 = ins[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    es = v && !fl && m.valid && m.mr && m.rd != 0 &&
         ((u1 && m.rd == ins[19:15]) || (u2 && m.rd == ins[24:20]));
    stall_q.push_back(es);
    if (!rst || fl || es || !v) m = '0;
    else m = decode_model(ins, pc, d1, d2, wbw, wbr, wbd);
    ex_q.push_back(m);
    last_stall = es;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (stall_q.size() > 0) begin
        logic e;
        e = stall_q.pop_front();
        n_checks++;
        if (stall !== e) begin
          n_fail++;
          $display("FAIL stall t=%0t got=%b exp=%b", $time, stall, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ex_q.size() > 0) begin
        ex_t e, a;
        e = ex_q.pop_front();
        a = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
             ex_funct3, ex_funct7b5, ex_opcode, ex_RegWrite, ex_MemRead, ex_MemWrite,
             ex_MemToReg, ex_AluSrc, ex_Branch, ex_Jump, ex_illegal};
        n_checks++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL ex_regs t=%0t got=%h exp=%h", $time, a, e);
        end
      end
    end
  end

  localparam logic [31:0] ADDI = 32'hFFF08293;
  localparam logic [31:0] LW6  = 32'h00012303;
  localparam logic [31:0] ADD7 = 32'h003303B3;
  localparam logic [31:0] LW0  = 32'h00012003;
  localparam logic [31:0] ADD0 = 32'h003003B3;

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] ins, pc;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    m = '0;
    last_stall = 1'b0;
    reset = 1'b0; Main_bus = '0; if_pc = '0; if_valid = 1'b0; flush = 1'b0;
    read_d1 = '0; read_d2 = '0; wb_RegWrite = 1'b0; wb_rd = '0; wb_data = '0;

    step(0, ADDI, 32'h100, 1, 0, 7, 0, 0, 0, 0);
    step(0, ADDI, 32'h100, 1, 0, 7, 0, 0, 0, 0);
    step(1, ADDI, 32'h100, 1, 0, 7, 0, 0, 0, 0);
    step(1, LW6,  32'h104, 1, 0, 32'h20, 0, 0, 0, 0);
    step(1, ADD7, 32'h108, 1, 0, 32'h1, 32'h2, 0, 0, 0);
    step(1, ADD7, 32'h108, 1, 0, 32'h1, 32'h2, 0, 0, 0);
    step(1, LW0,  32'h10C, 1, 0, 32'h20, 0, 0, 0, 0);
    step(1, ADD0, 32'h110, 1, 0, 32'h0, 32'h2, 0, 0, 0);
    step(1, LW6,  32'h114, 1, 0, 32'h20, 0, 0, 0, 0);
    step(1, ADD7, 32'h118, 1, 1, 32'h1, 32'h2, 0, 0, 0);
    step(1, ADDI, 32'h200, 1, 0, 32'h3, 0, 0, 0, 0);
    step(1, ADD7, 32'h204, 1, 0, 32'h9, 32'h11, 1, 5'd3, 32'h55);
    step(1, ADD7, 32'h208, 0, 0, 32'h9, 32'h11, 1, 5'd3, 32'h55);

    pc = 32'h1000;
    ins = ADDI;
    for (int i = 0; i < 2000; i++) begin
      logic rst, v, fl, wbw;
      rst = ($urandom_range(0, 99) >= 2);
      v   = ($urandom_range(0, 99) < 85);
      fl  = ($urandom_range(0, 99) < 8);
      wbw = $urandom_range(0, 1);
      if (!last_stall) begin
        ins = $urandom;
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
        pc = $urandom;
      end
      step(rst, ins, pc, v, fl, $urandom, $urandom, wbw, 5'($urandom_range(0, 3)), $urandom);
    end

    step(1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    if (ex_q.size() != 0 || stall_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending_ex=%0d pending_stall=%0d exp=0", ex_q.size(), stall_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
